// File: rtl/uart_pkg.sv
// Shared constants for the UART byte buffering path.
package uart_pkg;

    // Width of one UART character as seen by host and line side.
    localparam int UART_BYTE_W     = 8;

    // Default number of buffered bytes per direction.
    localparam int UART_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/byte_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy count.
// Pushes while full and pops while empty are ignored. Storage is not reset;
// the head output is forced to zero while empty so stale bytes never leak.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int DATA_W = UART_BYTE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DATA_W-1:0]        head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Flags are pure functions of the count register.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Byte storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is visible as soon as it is written; masked to zero when empty.
    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule : byte_fifo

// File: rtl/uart_fifo.sv
// Host-side buffering for a UART: a TX FIFO feeding the transmitter and an
// RX FIFO filled by the receiver, plus a sticky flag for dropped RX bytes.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             wr_data,
    input  logic                   wr_en,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [7:0]             tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_data_ack,
    input  logic [7:0]             rx_data,
    input  logic                   rx_data_fresh,
    output logic [7:0]             rd_data,
    input  logic                   rd_en,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   rx_overflow,
    input  logic                   ovf_clr
);

    logic tx_empty;
    logic rx_full;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (UART_BYTE_W)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (tx_data_ack),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count),
        .head_data (tx_data)
    );

    byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (UART_BYTE_W)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_data_fresh),
        .push_data (rx_data),
        .pop       (rd_en),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .head_data (rd_data)
    );

    assign tx_data_valid = !tx_empty;

    // Sticky overflow: a byte arriving into a full RX FIFO sets it, and a
    // drop in the same cycle as a clear request keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow <= 1'b0;
        end else if (rx_data_fresh && rx_full) begin
            rx_overflow <= 1'b1;
        end else if (ovf_clr) begin
            rx_overflow <= 1'b0;
        end
    end

endmodule : uart_fifo

// File: tb/tb_uart_fifo.sv
// Directed and randomized checks of uart_fifo against a queue-based model.
module tb_uart_fifo;

    localparam int D  = 16;
    localparam int CW = $clog2(D) + 1;

    logic          clk;
    logic          rst_n;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          tx_full;
    logic [CW-1:0] tx_count;
    logic [7:0]    tx_data;
    logic          tx_data_valid;
    logic          tx_data_ack;
    logic [7:0]    rx_data;
    logic          rx_data_fresh;
    logic [7:0]    rd_data;
    logic          rd_en;
    logic          rx_empty;
    logic [CW-1:0] rx_count;
    logic          rx_overflow;
    logic          ovf_clr;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_ovf;

    uart_fifo #(.DEPTH(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .tx_full       (tx_full),
        .tx_count      (tx_count),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ack   (tx_data_ack),
        .rx_data       (rx_data),
        .rx_data_fresh (rx_data_fresh),
        .rd_data       (rd_data),
        .rd_en         (rd_en),
        .rx_empty      (rx_empty),
        .rx_count      (rx_count),
        .rx_overflow   (rx_overflow),
        .ovf_clr       (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [7:0] th;
        logic [7:0] rh;
        th = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        rh = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        check("tx_count",      32'(tx_count),      32'(tx_q.size()));
        check("tx_full",       32'(tx_full),       32'(tx_q.size() == D));
        check("tx_data_valid", 32'(tx_data_valid), 32'(tx_q.size() != 0));
        check("tx_data",       32'(tx_data),       32'(th));
        check("rx_count",      32'(rx_count),      32'(rx_q.size()));
        check("rx_empty",      32'(rx_empty),      32'(rx_q.size() == 0));
        check("rd_data",       32'(rd_data),       32'(rh));
        check("rx_overflow",   32'(rx_overflow),   32'(m_ovf));
    endtask

    // One clock of stimulus; entered and left at posedge + 1.
    task automatic cycle(input bit we, input logic [7:0] wd, input bit ack,
                         input bit fresh, input logic [7:0] rd, input bit re,
                         input bit clr);
        bit tx_push, tx_pop, rx_push, rx_pop;
        logic [7:0] e;
        wr_en = we; wr_data = wd; tx_data_ack = ack;
        rx_data_fresh = fresh; rx_data = rd; rd_en = re; ovf_clr = clr;
        tx_push = we && (tx_q.size() < D);
        tx_pop  = ack && (tx_q.size() > 0);
        rx_push = fresh && (rx_q.size() < D);
        rx_pop  = re && (rx_q.size() > 0);
        #1;
        if (tx_pop) begin
            e = tx_q.pop_front();
            check("tx_ack_byte", 32'(tx_data), 32'(e));
            check("tx_ack_valid", 32'(tx_data_valid), 32'd1);
        end
        if (rx_pop) begin
            e = rx_q.pop_front();
            check("rd_byte", 32'(rd_data), 32'(e));
        end
        if (tx_push) tx_q.push_back(wd);
        if (rx_push) rx_q.push_back(rd);
        if (fresh && !rx_push) m_ovf = 1'b1;
        else if (clr)          m_ovf = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 0; tx_data_ack = 0; rx_data_fresh = 0; rd_en = 0; ovf_clr = 0;
        check_state();
    endtask

    initial begin
        rst_n = 0; wr_en = 0; wr_data = 0; tx_data_ack = 0;
        rx_data = 0; rx_data_fresh = 0; rd_en = 0; ovf_clr = 0;
        m_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst_n = 1;
        @(posedge clk);
        #1;

        // Single byte through TX with one-cycle latency, then ack.
        cycle(1, 8'hA5, 0, 0, 0, 0, 0);
        check("tx_a5_data", 32'(tx_data), 32'h A5);
        check("tx_a5_count", 32'(tx_count), 32'd1);
        cycle(0, 0, 1, 0, 0, 0, 0);
        check("tx_a5_empty", 32'(tx_data_valid), 32'd0);

        // Fill TX, reject one more, drain in order; extra ack while empty.
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0, 0, 0);
        check("tx_full_16", 32'(tx_full), 32'd1);
        cycle(1, 8'hFF, 0, 0, 0, 0, 0);
        check("tx_full_cnt", 32'(tx_count), 32'd16);
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // RX overflow on the 17th byte.
        for (int i = 0; i < 17; i++) cycle(0, 0, 0, 1, 8'(8'h10 + i), 0, 0);
        check("rx_cnt_16", 32'(rx_count), 32'd16);
        check("rx_ovf_set", 32'(rx_overflow), 32'd1);
        // Clear coincident with a drop: set wins; then a lone clear.
        cycle(0, 0, 0, 1, 8'h77, 0, 1);
        check("ovf_set_wins", 32'(rx_overflow), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("ovf_cleared", 32'(rx_overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Full RX with simultaneous read and arrival: pop, drop, flag.
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 8'(8'h80 + i), 0, 0);
        cycle(0, 0, 0, 1, 8'h55, 1, 0);
        check("rx_sim_cnt", 32'(rx_count), 32'd15);
        check("rx_sim_ovf", 32'(rx_overflow), 32'd1);
        for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        // Empty TX with push and ack together: push only.
        cycle(1, 8'h3C, 1, 0, 0, 0, 0);
        check("tx_sim_cnt", 32'(tx_count), 32'd1);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // Asynchronous reset with bytes buffered both ways.
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'hC0 + i), 0, 1, 8'(8'hD0 + i), 0, 0);
        check("pre_rst_tx", 32'(tx_count), 32'd5);
        #2;
        rst_n = 0;
        #1;
        tx_q.delete(); rx_q.delete(); m_ovf = 0;
        check_state();
        @(posedge clk);
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
        check_state();

        // Random traffic with pointer wrap.
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_uart_fifo
